// File: rtl/fdiv_pkg.sv
// Shared types and elaboration helpers for the sequential fractional divider.
package fdiv_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Iteration cycles needed to retire no+1 quotient bits, k bits per cycle.
  function automatic int unsigned calc_cycles(input int unsigned no, input int unsigned k);
    return (no + 1 + k - 1) / k;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fractional_divider_seq_step.sv
// One combinational restoring-division step on a W-bit partial remainder.
module fdiv_step #(
  parameter int unsigned W = 25
) (
  input  logic [W-1:0] pr,
  input  logic [W-1:0] br,
  output logic [W-1:0] pr_next,
  output logic         qbit
);

  logic [W-1:0] diff;
  logic [W-1:0] sel;
  logic         borrow;

  always_comb begin
    borrow  = pr < br;
    diff    = pr - br;
    sel     = borrow ? pr : diff;
    pr_next = sel << 1;
    qbit    = ~borrow;
  end

endmodule

// File: rtl/fractional_divider_seq.sv
// Bit-serial unsigned 1.NI / 1.NI restoring divider, K quotient bits per clock.
module fractional_divider_seq
  import fdiv_pkg::*;
#(
  parameter int unsigned NI = 23,
  parameter int unsigned NO = 25,
  parameter int unsigned K  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NI:0]   a,
  input  logic [NI:0]   b,
  output logic [NO:0]   q,
  output logic          sticky,
  output logic          dz,
  output logic          ovf,
  output logic          ready,
  output logic          done
);

  localparam int unsigned W   = NI + 2;
  localparam int unsigned N   = calc_cycles(NO, K);
  localparam int unsigned CW  = cnt_width(N);
  localparam int unsigned REM = (NO + 1) % K;

  state_e        state_q;
  logic [W-1:0]  pr_q;
  logic [W-1:0]  br_q;
  logic [NO:0]   q_q;
  logic [CW-1:0] cnt_q;
  logic          dz_pend_q;
  logic          ovf_pend_q;
  logic          sticky_q;
  logic          dz_q;
  logic          ovf_q;
  logic          ready_q;
  logic          done_q;

  logic          last_cyc;
  logic [K-1:0]  step_en;
  logic [W-1:0]  pr_d;
  logic [NO:0]   q_d;

  // The final cycle may retire fewer than K bits when K does not divide NO+1.
  always_comb begin
    last_cyc = (cnt_q == CW'(1));
    for (int unsigned j = 0; j < K; j++) begin
      step_en[j] = !(last_cyc && (REM != 0) && (j >= REM));
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_stage
    logic [W-1:0] pr_in;
    logic [W-1:0] pr_step;
    logic [W-1:0] pr_out;
    logic [NO:0]  q_in;
    logic [NO:0]  q_out;
    logic         qbit;

    if (j == 0) begin : g_first
      assign pr_in = pr_q;
      assign q_in  = q_q;
    end else begin : g_next
      assign pr_in = g_stage[j-1].pr_out;
      assign q_in  = g_stage[j-1].q_out;
    end

    fdiv_step #(
      .W(W)
    ) u_step (
      .pr     (pr_in),
      .br     (br_q),
      .pr_next(pr_step),
      .qbit   (qbit)
    );

    assign pr_out = step_en[j] ? pr_step : pr_in;
    assign q_out  = step_en[j] ? {q_in[NO-1:0], qbit} : q_in;
  end

  assign pr_d = g_stage[K-1].pr_out;
  assign q_d  = g_stage[K-1].q_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pr_q       <= '0;
      br_q       <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      sticky_q   <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // Start wins over completion and aborts any divide in flight.
        state_q    <= StRun;
        pr_q       <= {1'b0, a};
        br_q       <= {1'b0, b};
        q_q        <= '0;
        cnt_q      <= CW'(N);
        dz_pend_q  <= (b == '0);
        ovf_pend_q <= (b != '0) && ({1'b0, a} >= {b, 1'b0});
        sticky_q   <= 1'b0;
        dz_q       <= 1'b0;
        ovf_q      <= 1'b0;
        ready_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StRun: begin
            if (dz_pend_q || ovf_pend_q) begin
              q_q      <= '1;
              sticky_q <= 1'b0;
              dz_q     <= dz_pend_q;
              ovf_q    <= ovf_pend_q;
              state_q  <= StIdle;
              ready_q  <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              pr_q  <= pr_d;
              q_q   <= q_d;
              cnt_q <= cnt_q - CW'(1);
              if (last_cyc) begin
                sticky_q <= (pr_d != '0);
                state_q  <= StIdle;
                ready_q  <= 1'b1;
                done_q   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign q      = q_q;
  assign sticky = sticky_q;
  assign dz     = dz_q;
  assign ovf    = ovf_q;
  assign ready  = ready_q;
  assign done   = done_q;

endmodule
